// File: rtl/dpram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM and its clear engine.
package dpram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic int nb(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// One RAM port: read request, byte write enables, address, data in/out and read-valid.
interface dpram_be_clr_if
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  localparam int NB = nb(DATA_WIDTH);

  logic                  re;
  logic [NB-1:0]         we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;

  modport master (output re, output we, output addr, output din, input dout, input dvalid);
  modport slave  (input re, input we, input addr, input din, output dout, output dvalid);

endinterface

// File: rtl/dpram_clear_fsm.sv
// Clear sequencer: sweeps every word address once after reset or clear_req.
// Only instantiated when DPRAM_BE_CLR_CLEAR_EN is defined.
//
// state | meaning
// IDLE  | ports open, waiting for clear_req
// CLEAR | writing one word per cycle at cnt, ports blocked
// DONE  | one-cycle clear_done pulse, ports still blocked
module dpram_clear_fsm
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy,
  output logic                  clear_done
);

  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  // Reset lands directly in CLEAR so every reset yields a zeroed array.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clr_we     = 1'b0;
    busy       = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == '1) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        clear_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, read-first collisions and port-A priority.
// Define DPRAM_BE_CLR_CLEAR_EN to build the clear engine (busy/clear_done, clear on reset).
module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  dpram_be_clr_if.slave port_a,
  dpram_be_clr_if.slave port_b,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_done
);

  localparam int NB    = nb(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0 || READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_param_err
    $error("dpram_be_clr: DATA_WIDTH must be a multiple of 8 and READ_LATENCY must be 1 or 2");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef DPRAM_BE_CLR_CLEAR_EN
  dpram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .busy       (busy),
    .clear_done (clear_done)
  );
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign clr_we           = 1'b0;
  assign clr_addr         = '0;
  assign busy             = 1'b0;
  assign clear_done       = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            acc_re;
  logic [NB-1:0]         wa_en, wb_en;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;

  assign acc_re = {port_b.re, port_a.re} & {2{~busy}};
  assign wb_en  = port_b.we & {NB{~busy}};

  // The clear engine borrows the port A write path while the ports are blocked.
  assign wa_en   = clr_we ? {NB{1'b1}} : (port_a.we & {NB{~busy}});
  assign wa_addr = clr_we ? clr_addr   : port_a.addr;
  assign wa_data = clr_we ? CLEAR_VALUE : port_a.din;

  // Port A lanes are assigned last so they win a same-address, same-lane collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wb_en[i]) mem[port_b.addr][i*8 +: 8] <= port_b.din[i*8 +: 8];
      if (wa_en[i]) mem[wa_addr][i*8 +: 8]     <= wa_data[i*8 +: 8];
    end
  end

  logic [ADDR_WIDTH-1:0] rd_addr  [2];
  logic [DATA_WIDTH-1:0] rd_data  [2];
  logic                  rd_valid [2];

  assign rd_addr[0] = port_a.addr;
  assign rd_addr[1] = port_b.addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] q1;
    logic                  v1;

    // Nonblocking array read samples the pre-write word, giving read-first behaviour.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        q1 <= '0;
        v1 <= 1'b0;
      end else begin
        v1 <= acc_re[p];
        if (acc_re[p]) q1 <= mem[rd_addr[p]];
      end
    end

    if (READ_LATENCY == 2) begin : g_rl2
      logic [DATA_WIDTH-1:0] q2;
      logic                  v2;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) q2 <= q1;
        end
      end

      assign rd_data[p]  = q2;
      assign rd_valid[p] = v2;
    end else begin : g_rl1
      assign rd_data[p]  = q1;
      assign rd_valid[p] = v1;
    end
  end

  assign port_a.dout   = rd_data[0];
  assign port_a.dvalid = rd_valid[0];
  assign port_b.dout   = rd_data[1];
  assign port_b.dvalid = rd_valid[1];

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench for dpram_be_clr: latency-1 and latency-2 instances share identical stimulus.
// Covers the clear engine when DPRAM_BE_CLR_CLEAR_EN is defined, the open-port build otherwise.
module tb_dpram_be_clr;

  localparam int AW = 4;
  localparam int DW = 16;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic clear_req = 1'b0;
  logic busy1, busy2, done1, done2;

  int n_chk = 0;
  int n_err = 0;

  dpram_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pa ();
  dpram_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pb ();
  dpram_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pa2 ();
  dpram_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pb2 ();

  assign pa2.re   = pa.re;
  assign pa2.we   = pa.we;
  assign pa2.addr = pa.addr;
  assign pa2.din  = pa.din;
  assign pb2.re   = pb.re;
  assign pb2.we   = pb.we;
  assign pb2.addr = pb.addr;
  assign pb2.din  = pb.din;

  dpram_be_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .port_a     (pa.slave),
    .port_b     (pb.slave),
    .clear_req  (clear_req),
    .busy       (busy1),
    .clear_done (done1)
  );

  dpram_be_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .port_a     (pa2.slave),
    .port_b     (pb2.slave),
    .clear_req  (clear_req),
    .busy       (busy2),
    .clear_done (done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive both ports for one cycle, then step to just after the next rising edge.
  task automatic drive(input logic ra, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
                       input logic rb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] db);
    pa.re = ra; pa.we = wa; pa.addr = aa; pa.din = da;
    pb.re = rb; pb.we = wb; pb.addr = ab; pb.din = db;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
  endtask

  // Called right after the edge that accepted a read on the selected port.
  task automatic expect_rd(input string tag, input bit on_b, input logic [15:0] exp);
    chk({tag, ".rl1_valid"}, on_b ? pb.dvalid : pa.dvalid, 32'd1);
    chk({tag, ".rl1_data"},  on_b ? pb.dout   : pa.dout,   {16'h0, exp});
    chk({tag, ".rl2_early"}, on_b ? pb2.dvalid : pa2.dvalid, 32'd0);
    nop();
    chk({tag, ".rl2_valid"}, on_b ? pb2.dvalid : pa2.dvalid, 32'd1);
    chk({tag, ".rl2_data"},  on_b ? pb2.dout   : pa2.dout,   {16'h0, exp});
    chk({tag, ".rl1_drop"},  on_b ? pb.dvalid  : pa.dvalid,  32'd0);
    chk({tag, ".rl1_hold"},  on_b ? pb.dout    : pa.dout,    {16'h0, exp});
  endtask

  task automatic rd(input string tag, input bit on_b, input logic [3:0] addr, input logic [15:0] exp);
    if (on_b) drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 2'b00, addr, 16'h0);
    else      drive(1'b1, 2'b00, addr, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
    expect_rd(tag, on_b, exp);
  endtask

`ifdef DPRAM_BE_CLR_CLEAR_EN
  // Port inputs are left as the caller set them, so requests keep arriving during busy.
  task automatic busy_window(input string tag);
    int n      = 0;
    int pulses = 0;
    int dv     = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      pulses += int'(done1);
      dv     += int'(pa.dvalid) + int'(pb.dvalid) + int'(pa2.dvalid) + int'(pb2.dvalid);
    end while (busy1 && n < 64);
    chk({tag, ".busy_cycles"}, n, 32'd17);
    chk({tag, ".done_pulses"}, pulses, 32'd1);
    chk({tag, ".dvalid_during_busy"}, dv, 32'd0);
    chk({tag, ".busy_rl2"}, busy2, 32'd0);
  endtask
`endif

  initial begin
    pa.re = 1'b0; pa.we = '0; pa.addr = '0; pa.din = '0;
    pb.re = 1'b0; pb.we = '0; pb.addr = '0; pb.din = '0;

    reset_n = 1'b0;
    repeat (3) nop();
    chk("rst.dout_a",   pa.dout,   32'h0);
    chk("rst.dvalid_a", pa.dvalid, 32'h0);
    chk("rst.dout_b",   pb.dout,   32'h0);
    chk("rst.dvalid_b", pb.dvalid, 32'h0);
    chk("rst.dout_a2",  pa2.dout,  32'h0);
    chk("rst.dvalid_b2", pb2.dvalid, 32'h0);
    chk("rst.clear_done", done1, 32'h0);

`ifdef DPRAM_BE_CLR_CLEAR_EN
    chk("rst.busy", busy1, 32'd1);
    reset_n = 1'b1;
    busy_window("boot");
    for (int i = 0; i < 16; i++) rd("boot_zero", (i % 2) == 1, 4'(i), 16'h0000);
`else
    reset_n = 1'b1;
    chk("open.busy_first", busy1, 32'd0);
    drive(1'b0, 2'b11, 4'd0, 16'hC0DE, 1'b0, 2'b00, 4'd0, 16'h0);
    rd("open.addr0", 1'b0, 4'd0, 16'hC0DE);
    clear_req = 1'b1;
    nop();
    clear_req = 1'b0;
    chk("open.busy_after_req", busy1, 32'd0);
    chk("open.done_after_req", done1, 32'd0);
    nop();
    chk("open.busy_later", busy1, 32'd0);
    rd("open.addr0_kept", 1'b1, 4'd0, 16'hC0DE);
`endif

    // Byte-lane merge on a single port.
    drive(1'b0, 2'b11, 4'd3, 16'hA55A, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b0, 2'b01, 4'd3, 16'h00FF, 1'b0, 2'b00, 4'd0, 16'h0);
    rd("lane.addr3", 1'b1, 4'd3, 16'hA5FF);

    // Dual writes to one address: A owns the lanes it enables.
    drive(1'b0, 2'b01, 4'd5, 16'h1111, 1'b0, 2'b11, 4'd5, 16'h2222);
    rd("dual.a_lo", 1'b0, 4'd5, 16'h2211);
    drive(1'b0, 2'b11, 4'd5, 16'h1111, 1'b0, 2'b11, 4'd5, 16'h2222);
    rd("dual.a_all", 1'b1, 4'd5, 16'h1111);
    drive(1'b0, 2'b10, 4'd5, 16'h3300, 1'b0, 2'b01, 4'd5, 16'h0044);
    rd("dual.split", 1'b0, 4'd5, 16'h3344);

    // Read-first across ports, both directions.
    drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b11, 4'd7, 16'hBEEF);
    drive(1'b1, 2'b00, 4'd7, 16'h0, 1'b0, 2'b11, 4'd7, 16'h1234);
    expect_rd("rf.cross_old", 1'b0, 16'hBEEF);
    rd("rf.cross_new", 1'b0, 4'd7, 16'h1234);
    drive(1'b0, 2'b11, 4'd10, 16'hAAAA, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b0, 2'b11, 4'd10, 16'hBBBB, 1'b1, 2'b00, 4'd10, 16'h0);
    expect_rd("rf.cross_b_old", 1'b1, 16'hAAAA);

    // Read-first on the same port.
    drive(1'b0, 2'b11, 4'd8, 16'h0808, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b1, 2'b11, 4'd8, 16'h8888, 1'b0, 2'b00, 4'd0, 16'h0);
    expect_rd("rf.same_old", 1'b0, 16'h0808);
    rd("rf.same_new", 1'b1, 4'd8, 16'h8888);

`ifdef DPRAM_BE_CLR_CLEAR_EN
    drive(1'b0, 2'b11, 4'd9, 16'h5555, 1'b0, 2'b00, 4'd0, 16'h0);
    rd("clr.pre", 1'b0, 4'd9, 16'h5555);
    // A read issued alongside clear_req is still accepted and must complete.
    clear_req = 1'b1;
    drive(1'b1, 2'b00, 4'd9, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
    clear_req = 1'b0;
    chk("clr.busy_rise", busy1, 32'd1);
    expect_rd("clr.last_read", 1'b0, 16'h5555);
    repeat (6) nop();
    chk("clr.mid_busy", busy1, 32'd1);
    reset_n = 1'b0;
    drive(1'b1, 2'b00, 4'd9, 16'h0, 1'b0, 2'b11, 4'd9, 16'hFFFF);
    reset_n = 1'b1;
    busy_window("restart");
    nop();
    rd("clr.addr9", 1'b0, 4'd9, 16'h0000);
    rd("clr.addr3", 1'b1, 4'd3, 16'h0000);
    rd("clr.addr15", 1'b0, 4'd15, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "timeout");
  end

endmodule
